vga_timing_monitor: RTL

- Synthesizable, parametrised VGA timing checker for the display path; the hardware successor to the per-clock sync/RGB logging bench.
- Samples hsync, vsync and RGB on pixel-enable, measures line and frame geometry, and locks when the geometry matches the configured mode.
- Flags sticky timing and blanking errors so on-chip self-test and the sim bench can judge the top_level VGA output without dumping text files.

---
 rtl/vga_timing_monitor.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures sync geometry on pix_ce samples, locks to the configured mode, flags sticky errors.
// Optional per-frame CRC-16-CCITT of active pixels when VGA_MON_CRC_EN is defined.
module vga_timing_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned CNT_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    input  logic               err_clr,
    output logic               locked,
    output logic [4:0]         err,
    output logic [CNT_W-1:0]   h_total_meas,
    output logic [CNT_W-1:0]   h_sync_meas,
    output logic [CNT_W-1:0]   v_total_meas,
    output logic [CNT_W-1:0]   v_sync_meas,
    output logic [15:0]        frame_cnt
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0]        frame_crc,
    output logic               crc_valid
`endif
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_WIN_LO = H_SYNC + H_BP;
    localparam int unsigned H_WIN_HI = H_SYNC + H_BP + H_ACTIVE - 1;
    localparam int unsigned V_WIN_LO = V_SYNC + V_BP;
    localparam int unsigned V_WIN_HI = V_SYNC + V_BP + V_ACTIVE - 1;
    localparam int unsigned TIMEOUT  = 2 * H_TOTAL;
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               armed, armed_next;
    logic               hs_prev, vs_prev;
    logic [CNT_W-1:0]   hcnt, vcnt;

    logic               hs_act, vs_act, h_edge, v_edge;
    logic [CNT_W-1:0]   hcnt_inc, vcnt_inc, h_pos, v_pos;
    logic               in_active, pix_nz, timeout;
    logic               h_tot_ok, h_sync_ok, v_tot_ok, v_sync_ok;
    logic [4:0]         err_set;
    logic               frame_inc;

    // Per-sample decode; h_pos/v_pos are the counter values this sample will take.
    always_comb begin
        hs_act    = (hsync == SYNC_ACT);
        vs_act    = (vsync == SYNC_ACT);
        h_edge    = hs_act & ~hs_prev;
        v_edge    = vs_act & ~vs_prev;
        hcnt_inc  = (&hcnt) ? hcnt : hcnt + CNT_W'(1);
        vcnt_inc  = (&vcnt) ? vcnt : vcnt + CNT_W'(1);
        h_pos     = h_edge ? '0 : hcnt_inc;
        v_pos     = v_edge ? '0 : (h_edge ? vcnt_inc : vcnt);
        in_active = (h_pos >= CNT_W'(H_WIN_LO)) && (h_pos <= CNT_W'(H_WIN_HI)) &&
                    (v_pos >= CNT_W'(V_WIN_LO)) && (v_pos <= CNT_W'(V_WIN_HI));
        pix_nz    = |{red, green, blue};
        timeout   = (h_pos == CNT_W'(TIMEOUT));
        h_tot_ok  = ((h_edge ? hcnt_inc : h_total_meas) == CNT_W'(H_TOTAL));
        h_sync_ok = (h_sync_meas == CNT_W'(H_SYNC));
        v_tot_ok  = (vcnt_inc == CNT_W'(V_TOTAL));
        v_sync_ok = (v_sync_meas == CNT_W'(V_SYNC));
    end

    // Lock FSM; armed means MEASURE has seen a full frame start since it was entered.
    always_comb begin
        state_next = state;
        armed_next = armed;
        err_set    = '0;
        frame_inc  = 1'b0;
        if (pix_ce) begin
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state_next = MEASURE;
                        armed_next = 1'b1;
                    end
                end
                MEASURE: begin
                    if (v_edge) begin
                        if (armed && h_tot_ok && h_sync_ok && v_tot_ok && v_sync_ok) begin
                            state_next = LOCKED;
                        end
                        armed_next = 1'b1;
                    end
                end
                LOCKED: begin
                    if (h_edge) begin
                        err_set[0] = ~h_tot_ok;
                        err_set[1] = ~h_sync_ok;
                    end
                    if (v_edge) begin
                        frame_inc  = 1'b1;
                        err_set[2] = ~(v_tot_ok & v_sync_ok);
                    end
                    if (!in_active && pix_nz) begin
                        err_set[3] = 1'b1;
                    end
                    if (|err_set[2:0]) begin
                        state_next = MEASURE;
                        armed_next = v_edge;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    armed_next = 1'b0;
                end
            endcase
            if ((state != SEARCH) && timeout) begin
                err_set[4] = 1'b1;
                state_next = SEARCH;
                armed_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= armed_next;
        end
    end

    // Error flags: clear first so a same-cycle new error still sets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err    <= '0;
            locked <= 1'b0;
        end else begin
            err    <= (err & ~{5{err_clr}}) | err_set;
            locked <= (state_next == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            hcnt         <= '0;
            vcnt         <= '0;
            h_total_meas <= '0;
            h_sync_meas  <= '0;
            v_total_meas <= '0;
            v_sync_meas  <= '0;
            frame_cnt    <= '0;
        end else if (pix_ce) begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            hcnt    <= h_pos;
            vcnt    <= v_pos;
            if (h_edge) begin
                h_total_meas <= hcnt_inc;
                h_sync_meas  <= CNT_W'(1);
            end else if (hs_act && hs_prev && !(&h_sync_meas)) begin
                h_sync_meas <= h_sync_meas + CNT_W'(1);
            end
            // Line at the vsync edge counts towards the vsync width.
            if (v_edge) begin
                v_total_meas <= vcnt_inc;
                v_sync_meas  <= h_edge ? CNT_W'(1) : '0;
            end else if (vs_act && h_edge && !(&v_sync_meas)) begin
                v_sync_meas <= v_sync_meas + CNT_W'(1);
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    localparam int unsigned PIX_W = 3 * COLOR_W;

    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [PIX_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // CRC over active pixels of each locked frame, latched at the next vsync edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= pix_ce && v_edge && (state == LOCKED);
            if (pix_ce) begin
                if (state != LOCKED) begin
                    crc <= 16'hFFFF;
                end else if (v_edge) begin
                    frame_crc <= crc;
                    crc       <= 16'hFFFF;
                end else if (in_active) begin
                    crc <= crc_step(crc, {red, green, blue});
                end
            end
        end
    end
`endif

endmodule
